// File: rtl/pkt_queue_rd.sv
// pkt_queue_rd: read side of the packet store-and-forward queue.
//
// The write side fills a dual-port RAM with words {valid, data, last, mty}. It
// publishes commit_ptr, which only moves past words that belong to complete
// packets. This block reads committed words through RAM port B, which has one
// cycle of read latency. It replays them as an AXI-stream master with full
// tready backpressure, and it hands rd_ptr back to the write side for full
// detection.
//
// Ports
//   aclk, areset        clock (shared with RAM port B); synchronous active-high reset
//   commit_ptr          one past the last committed word; MSB is the wrap bit
//   rd_ptr              next word to read; MSB is the wrap bit
//   ram_addrb           RAM port B address
//   ram_doutb           RAM port B data, one cycle after ram_addrb
//   m_axis_*            AXI-stream master (tvalid/tdata/tlast/tuser_mty, tready in)
//   pkt_cnt             count of tlast handshakes, wraps at 2^32
//   fmt_err             sticky; a word read from RAM had its valid bit clear
module pkt_queue_rd #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MTY_W  = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = DATA_W + MTY_W + 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W:0]   commit_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [WORD_W-1:0] ram_doutb,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [MTY_W-1:0]  m_axis_tuser_mty,
  input  logic              m_axis_tready,
  output logic [31:0]       pkt_cnt,
  output logic              fmt_err
);

  typedef enum logic [0:0] {StIdle, StInPkt} pkt_state_e;

  // Read pointer and the one-deep read pipeline
  logic [ADDR_W:0] rd_ptr_q;
  logic            rd_pend_q;   // a read was issued last cycle; its word is on ram_doutb now

  // Two-entry output buffer: the head entry is the registered m_axis outputs,
  // and the skid entry holds a second word while the head is stalled.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [MTY_W-1:0]  out_mty_q, out_mty_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;
  logic [MTY_W-1:0]  skid_mty_q, skid_mty_d;

  logic [31:0] pkt_cnt_q;
  logic        fmt_err_q;
  pkt_state_e  pkt_state_q;

  logic              empty;
  logic              pop;
  logic              issue;
  logic [1:0]        occ_after;
  logic [1:0]        ahead;
  logic              cap_ok;
  logic [DATA_W-1:0] cap_data;
  logic              cap_last;
  logic [MTY_W-1:0]  cap_mty;

  assign empty = (rd_ptr_q == commit_ptr);
  assign pop   = out_valid_q & m_axis_tready;

  // Words still buffered once this cycle's beat (if any) has left, plus the
  // read in flight. Counting net of the departing beat keeps one beat per
  // cycle with only two entries, and still never holds more than two words.
  always_comb begin
    occ_after = {1'b0, out_valid_q} + {1'b0, skid_valid_q} - {1'b0, pop};
    ahead     = occ_after + {1'b0, rd_pend_q};
  end

  assign issue = !empty && (ahead < 2'd2);

  assign cap_ok   = ram_doutb[WORD_W-1];
  assign cap_data = ram_doutb[DATA_W+MTY_W:MTY_W+1];
  assign cap_last = ram_doutb[MTY_W];
  assign cap_mty  = ram_doutb[MTY_W-1:0];

  // Buffer next state. A word that arrives from RAM goes to the head when the
  // head is free, or is being vacated with nothing in skid. Otherwise it goes
  // to skid. Order is preserved because skid always drains into the head first.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_mty_d    = out_mty_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_mty_d   = skid_mty_q;
    if (pop) begin
      if (skid_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        out_mty_d   = skid_mty_q;
        if (rd_pend_q) begin
          skid_data_d = cap_data;
          skid_last_d = cap_last;
          skid_mty_d  = cap_mty;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (rd_pend_q) begin
        out_valid_d = 1'b1;
        out_data_d  = cap_data;
        out_last_d  = cap_last;
        out_mty_d   = cap_mty;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = cap_data;
        out_last_d  = cap_last;
        out_mty_d   = cap_mty;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = cap_data;
        skid_last_d  = cap_last;
        skid_mty_d   = cap_mty;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr_q     <= '0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_mty_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_mty_q   <= '0;
      fmt_err_q    <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + (ADDR_W + 1)'(1);
      end
      rd_pend_q    <= issue;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_mty_q    <= out_mty_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_mty_q   <= skid_mty_d;
      // A malformed word is flagged but still forwarded.
      if (rd_pend_q && !cap_ok) begin
        fmt_err_q <= 1'b1;
      end
    end
  end

  // Packet-boundary tracker over output handshakes. It is kept for debug
  // visibility only and never gates reads.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_state_q <= StIdle;
      pkt_cnt_q   <= '0;
    end else if (pop) begin
      if (out_last_q) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      case (pkt_state_q)
        StIdle:  if (!out_last_q) pkt_state_q <= StInPkt;
        StInPkt: if (out_last_q) pkt_state_q <= StIdle;
        default: pkt_state_q <= StIdle;
      endcase
    end
  end

  assign rd_ptr           = rd_ptr_q;
  assign ram_addrb        = rd_ptr_q[ADDR_W-1:0];
  assign m_axis_tvalid    = out_valid_q;
  assign m_axis_tdata     = out_data_q;
  assign m_axis_tlast     = out_last_q;
  assign m_axis_tuser_mty = out_mty_q;
  assign pkt_cnt          = pkt_cnt_q;
  assign fmt_err          = fmt_err_q;

endmodule

// File: tb/tb_pkt_queue_rd.sv
`timescale 1ns/1ps
module tb_pkt_queue_rd;

  localparam int DATA_W  = 8;
  localparam int MTY_W   = 8;
  localparam int ADDR_W  = 6;
  localparam int WORD_W  = DATA_W + MTY_W + 2;
  localparam int DEPTH   = 64;
  localparam int PTR_MOD = 128;

  typedef struct packed {
    logic       ok;
    logic [7:0] data;
    logic       last;
    logic [7:0] mty;
  } word_t;

  typedef struct {
    int         commit;   // -1 leaves commit_ptr unchanged
    bit         rdy;
    bit         v;
    logic [7:0] d;
    bit         l;
    logic [7:0] m;
    int         rd;
    int         pc;
  } vec_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [ADDR_W:0]   commit_ptr = '0;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W-1:0] ram_addrb;
  logic [WORD_W-1:0] ram_doutb;
  logic              m_axis_tvalid;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic [MTY_W-1:0]  m_axis_tuser_mty;
  logic              m_axis_tready = 1'b0;
  logic [31:0]       pkt_cnt;
  logic              fmt_err;

  pkt_queue_rd #(
    .DATA_W(DATA_W),
    .MTY_W (MTY_W),
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .commit_ptr      (commit_ptr),
    .rd_ptr          (rd_ptr),
    .ram_addrb       (ram_addrb),
    .ram_doutb       (ram_doutb),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser_mty(m_axis_tuser_mty),
    .m_axis_tready   (m_axis_tready),
    .pkt_cnt         (pkt_cnt),
    .fmt_err         (fmt_err)
  );

  always #5 aclk = ~aclk;

  // RAM port B: registered read, one cycle latency
  word_t mem [DEPTH];
  always @(posedge aclk) ram_doutb <= mem[ram_addrb];

  // Reference model: committed words in order, awaiting their output beat
  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    hs_cnt = 0;      // beats since reset, mod 128
  int    exp_pkt = 0;
  int    wr_ptr = 0;      // bench write pointer (unbounded)
  int    commit_int = 0;  // committed words since reset (unbounded)
  bit    prev_stall = 0;
  logic [DATA_W+MTY_W:0] prev_beat;

  task automatic tally(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    tally(act == req, name, act, req);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_pkt(input int len, input bit bad_first);
    for (int i = 0; i < len; i++) begin
      word_t w;
      w.ok   = !(bad_first && i == 0);
      w.data = 8'($urandom);
      w.last = (i == len - 1);
      w.mty  = w.last ? 8'($urandom_range(0, 7)) : 8'h00;
      mem[wr_ptr % DEPTH] = w;
      wr_ptr++;
    end
  endtask

  task automatic commit_upto(input int n);
    while (commit_int < n) begin
      exp_q.push_back(mem[commit_int % DEPTH]);
      commit_int++;
    end
    commit_ptr = 7'(commit_int % PTR_MOD);
  endtask

  task automatic do_reset(input int cycles);
    areset        = 1'b1;
    m_axis_tready = 1'b0;
    commit_ptr    = '0;
    commit_int    = 0;
    wr_ptr        = 0;
    repeat (cycles) tick();
    areset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    m_axis_tready = 1'b1;
    n = 0;
    while (!(exp_q.size() == 0 && !m_axis_tvalid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: scoreboard, stall stability, read-ahead and empty bounds
  always @(negedge aclk) begin
    int ahead;
    int win;
    if (areset) begin
      exp_q.delete();
      hs_cnt     = 0;
      exp_pkt    = 0;
      prev_stall = 0;
    end else begin
      ahead = ((int'(rd_ptr) - hs_cnt) % PTR_MOD + PTR_MOD) % PTR_MOD;
      tally(ahead <= 2, "read_ahead", ahead, 2);
      win = ((int'(commit_ptr) - int'(rd_ptr)) % PTR_MOD + PTR_MOD) % PTR_MOD;
      tally(win <= DEPTH, "read_past_commit", win, DEPTH);
      chk("pkt_cnt", pkt_cnt, exp_pkt);
      if (prev_stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty}, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tally(1'b0, "unexpected_beat", m_axis_tdata, 0);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, w.data);
          chk("beat_last", m_axis_tlast, w.last);
          if (w.last) begin
            chk("beat_mty", m_axis_tuser_mty, w.mty);
            exp_pkt++;
          end
        end
        hs_cnt = (hs_cnt + 1) % PTR_MOD;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty};
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    int   seq[$];
    int   last_addr;

    vecs[0]  = '{3,  1, 0, 8'h00, 0, 8'h00, 0, 0};
    vecs[1]  = '{-1, 1, 0, 8'h00, 0, 8'h00, 1, 0};
    vecs[2]  = '{-1, 1, 1, 8'h11, 0, 8'h00, 2, 0};
    vecs[3]  = '{-1, 1, 1, 8'h22, 0, 8'h00, 3, 0};
    vecs[4]  = '{-1, 1, 1, 8'h33, 1, 8'h05, 3, 0};
    vecs[5]  = '{-1, 1, 0, 8'h00, 0, 8'h00, 3, 1};
    vecs[6]  = '{6,  0, 0, 8'h00, 0, 8'h00, 3, 1};
    vecs[7]  = '{-1, 0, 0, 8'h00, 0, 8'h00, 4, 1};
    vecs[8]  = '{-1, 0, 1, 8'h44, 0, 8'h00, 5, 1};
    vecs[9]  = '{-1, 0, 1, 8'h44, 0, 8'h00, 5, 1};
    vecs[10] = '{-1, 1, 1, 8'h44, 0, 8'h00, 5, 1};
    vecs[11] = '{-1, 1, 1, 8'h55, 0, 8'h00, 6, 1};
    vecs[12] = '{-1, 1, 1, 8'h66, 1, 8'h02, 6, 1};
    vecs[13] = '{-1, 1, 0, 8'h00, 0, 8'h00, 6, 2};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    tick();
    do_reset(3);

    // Reset state
    @(negedge aclk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_addrb", ram_addrb, 0);
    chk("rst_tdata", {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty}, 0);
    chk("rst_fmt_err", fmt_err, 0);
    tick();

    // Two packets preloaded; second stays uncommitted until its table row
    mem[0] = '{1'b1, 8'h11, 1'b0, 8'h00};
    mem[1] = '{1'b1, 8'h22, 1'b0, 8'h00};
    mem[2] = '{1'b1, 8'h33, 1'b1, 8'h05};
    mem[3] = '{1'b1, 8'h44, 1'b0, 8'h00};
    mem[4] = '{1'b1, 8'h55, 1'b0, 8'h00};
    mem[5] = '{1'b1, 8'h66, 1'b1, 8'h02};
    wr_ptr = 6;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].commit >= 0) commit_upto(vecs[i].commit);
      m_axis_tready = vecs[i].rdy;
      @(negedge aclk);
      chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].v);
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].d);
        chk($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].l);
        if (vecs[i].l) chk($sformatf("vec%0d_mty", i), m_axis_tuser_mty, vecs[i].m);
      end
      chk($sformatf("vec%0d_rd_ptr", i), rd_ptr, vecs[i].rd);
      chk($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, vecs[i].pc);
      tick();
    end

    // Partial packet stays hidden until committed
    write_pkt(4, 0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      chk("hidden_tvalid", m_axis_tvalid, 0);
      chk("hidden_rd_ptr", rd_ptr, 6);
      tick();
    end
    commit_upto(wr_ptr);
    drain(50);
    chk("hidden_rd_end", rd_ptr, 10);
    chk("hidden_pkt_cnt", pkt_cnt, 3);

    // Backpressure: tready 1,0,0,1 repeating over 10 words
    write_pkt(5, 0);
    write_pkt(5, 0);
    commit_upto(wr_ptr);
    for (int c = 0; c < 40; c++) begin
      m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    drain(50);
    chk("bp_rd_ptr", rd_ptr, 20);

    // Random traffic and backpressure against the scoreboard
    for (int c = 0; c < 500; c++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (wr_ptr == commit_int) begin
        if ($urandom_range(0, 2) == 0) begin
          int len;
          len = $urandom_range(1, 6);
          if (exp_q.size() + len <= 60) write_pkt(len, 0);
        end
      end else if ($urandom_range(0, 1) == 1) begin
        commit_upto(wr_ptr);
      end
      tick();
    end
    commit_upto(wr_ptr);
    drain(300);
    chk("rand_rd_ptr", rd_ptr, commit_int % PTR_MOD);
    chk("rand_fmt_err", fmt_err, 0);

    // Format error is sticky; reset mid-packet clears everything
    write_pkt(4, 1);
    commit_upto(wr_ptr);
    m_axis_tready = 1'b1;
    repeat (4) tick();
    m_axis_tready = 1'b0;
    @(negedge aclk);
    chk("fmt_err_set", fmt_err, 1);
    chk("fmt_tvalid_mid", m_axis_tvalid, 1);
    repeat (5) tick();
    @(negedge aclk);
    chk("fmt_err_sticky", fmt_err, 1);
    chk("stall_before_rst", m_axis_tvalid, 1);
    tick();
    do_reset(1);
    @(negedge aclk);
    chk("rst_mid_tvalid", m_axis_tvalid, 0);
    chk("rst_mid_rd_ptr", rd_ptr, 0);
    chk("rst_mid_pkt_cnt", pkt_cnt, 0);
    chk("rst_mid_fmt_err", fmt_err, 0);
    tick();

    // Wrap-around: bring pointers to 62, then a 4-word packet across the end
    for (int i = 0; i < 31; i++) write_pkt(2, 0);
    commit_upto(wr_ptr);
    drain(200);
    chk("wrap_pre_rd_ptr", rd_ptr, 62);
    write_pkt(4, 0);
    commit_upto(wr_ptr);
    m_axis_tready = 1'b1;
    last_addr = 62;
    seq.push_back(62);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (int'(ram_addrb) != last_addr) begin
        last_addr = int'(ram_addrb);
        seq.push_back(last_addr);
      end
      tick();
    end
    drain(50);
    tally(seq.size() >= 4, "wrap_seq_len", seq.size(), 4);
    if (seq.size() >= 4) begin
      chk("wrap_addr0", seq[0], 62);
      chk("wrap_addr1", seq[1], 63);
      chk("wrap_addr2", seq[2], 0);
      chk("wrap_addr3", seq[3], 1);
    end
    chk("wrap_rd_ptr", rd_ptr, 7'h42);
    chk("wrap_msb", rd_ptr[ADDR_W], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
